// File: rtl/inst_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder_loader
// Description : Encodes LEGv8 instruction fields into 32-bit words and streams
//               them to instruction memory at consecutive +4 byte addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder_loader #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [25:0]       imm,
  input  logic [1:0]        hw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              err
);

  localparam logic [3:0] c_OP_ANDREG = 4'd0;
  localparam logic [3:0] c_OP_ORRREG = 4'd1;
  localparam logic [3:0] c_OP_ADDREG = 4'd2;
  localparam logic [3:0] c_OP_SUBREG = 4'd3;
  localparam logic [3:0] c_OP_ADDIMM = 4'd4;
  localparam logic [3:0] c_OP_SUBIMM = 4'd5;
  localparam logic [3:0] c_OP_MOVZ   = 4'd6;
  localparam logic [3:0] c_OP_B      = 4'd7;
  localparam logic [3:0] c_OP_CBZ    = 4'd8;
  localparam logic [3:0] c_OP_LDUR   = 4'd9;
  localparam logic [3:0] c_OP_STUR   = 4'd10;

  localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

  logic              out_valid_q, out_valid_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              err_q, err_d;

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_in_fire;
  logic        w_out_fire;

  // Signed-fit checks: every bit above the field's sign bit must match it.
  logic w_fit_s9;
  logic w_fit_s19;
  assign w_fit_s9  = (&imm[25:8])  || !(|imm[25:8]);
  assign w_fit_s19 = (&imm[25:18]) || !(|imm[25:18]);

  always_comb begin
    w_word  = 32'h0;
    w_legal = 1'b1;
    case (op)
      c_OP_ANDREG: w_word = {11'b10001010000, rm, 6'b000000, rn, rd};
      c_OP_ORRREG: w_word = {11'b10101010000, rm, 6'b000000, rn, rd};
      c_OP_ADDREG: w_word = {11'b10001011000, rm, 6'b000000, rn, rd};
      c_OP_SUBREG: w_word = {11'b11001011000, rm, 6'b000000, rn, rd};
      c_OP_ADDIMM: begin
        w_word  = {10'b1001000100, imm[11:0], rn, rd};
        w_legal = (imm[25:12] == 14'd0);
      end
      c_OP_SUBIMM: begin
        w_word  = {10'b1101000100, imm[11:0], rn, rd};
        w_legal = (imm[25:12] == 14'd0);
      end
      c_OP_MOVZ: begin
        w_word  = {9'b110100101, hw, imm[15:0], rd};
        w_legal = (imm[25:16] == 10'd0);
      end
      c_OP_B: w_word = {6'b000101, imm};
      c_OP_CBZ: begin
        w_word  = {8'b10110100, imm[18:0], rd};
        w_legal = w_fit_s19;
      end
      c_OP_LDUR: begin
        w_word  = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
        w_legal = w_fit_s9;
      end
      c_OP_STUR: begin
        w_word  = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
        w_legal = w_fit_s9;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign in_ready   = !start && (!out_valid_q || out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    wdata_d      = wdata_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    err_d        = err_q;
    if (start) begin
      out_valid_d  = 1'b0;
      ptr_d        = {base_addr[ADDR_W-1:2], 2'b00};
      word_count_d = '0;
      err_count_d  = '0;
      err_d        = 1'b0;
    end else begin
      if (w_out_fire) begin
        out_valid_d = 1'b0;
        ptr_d       = ptr_q + c_ADDR_STEP;
        if (word_count_q != '1) word_count_d = word_count_q + c_CNT_ONE;
      end
      // A new accept in the same cycle as a write overrides the clear above.
      if (w_in_fire) begin
        if (w_legal) begin
          out_valid_d = 1'b1;
          wdata_d     = w_word;
        end else begin
          err_d = 1'b1;
          if (err_count_q != '1) err_count_d = err_count_q + c_CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      wdata_q      <= 32'h0;
      ptr_q        <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      wdata_q      <= wdata_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
      err_q        <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign imem_addr  = ptr_q;
  assign imem_wdata = wdata_q;
  assign word_count = word_count_q;
  assign err_count  = err_count_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder_loader
// Description : Scoreboard bench for inst_encoder_loader (narrow counters so
//               saturation is reachable quickly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder_loader;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              reset, start, in_valid, in_ready, out_valid, out_ready, err;
  logic [ADDR_W-1:0] base_addr, imem_addr;
  logic [3:0]        op;
  logic [4:0]        rd, rn, rm;
  logic [25:0]       imm;
  logic [1:0]        hw;
  logic [31:0]       imem_wdata;
  logic [CNT_W-1:0]  word_count, err_count;

  inst_encoder_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd), .rn(rn),
    .rm(rm), .imm(imm), .hw(hw), .out_valid(out_valid), .out_ready(out_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
    .err_count(err_count), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;
    logic [1:0]  hw;
    logic [31:0] exp;
    bit          legal;
  } item_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } word_t;

  item_t             items[$];
  word_t             sb[$];
  int                pop_cyc[$];
  logic [ADDR_W-1:0] exp_ptr;
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;

  function automatic item_t mk(input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                               input logic [4:0] m, input logic [25:0] i, input logic [1:0] h,
                               input logic [31:0] e, input bit l);
    item_t it;
    it.op = o; it.rd = d; it.rn = n; it.rm = m; it.imm = i; it.hw = h; it.exp = e; it.legal = l;
    return it;
  endfunction

  // Memory-side monitor: runs once per cycle, before the active edge.
  task automatic mon();
    word_t e;
    if (!reset && !start && out_valid && out_ready) begin
      checks++;
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got addr=%h data=%h required no word", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL word got addr=%h data=%h required addr=%h data=%h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic step(output bit acc);
    #1;
    mon();
    acc = in_valid && in_ready;
    @(posedge CLK);
    #2;
    cyc++;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    bit a;
    start = 1'b1; base_addr = base; in_valid = 1'b0;
    step(a);
    start = 1'b0;
    sb.delete();
    exp_ptr = base & ~ADDR_W'(3);
  endtask

  task automatic run_items(input int stall, input bit chk_hold, output int ncyc);
    int                idx;
    bit                acc;
    logic [31:0]       hold_data;
    logic [ADDR_W-1:0] hold_addr;
    word_t             w;
    idx = 0; ncyc = 0;
    hold_data = items[0].exp;
    hold_addr = exp_ptr;
    out_ready = (stall == 0);
    while (idx < items.size() && ncyc < 100) begin
      in_valid = 1'b1;
      op = items[idx].op; rd = items[idx].rd; rn = items[idx].rn; rm = items[idx].rm;
      imm = items[idx].imm; hw = items[idx].hw;
      if (chk_hold && ncyc >= 1 && ncyc < stall) begin
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || imem_wdata !== hold_data || imem_addr !== hold_addr) begin
          errors++;
          $display("FAIL hold got in_ready=%b out_valid=%b addr=%h data=%h required 0 1 %h %h",
                   in_ready, out_valid, imem_addr, imem_wdata, hold_addr, hold_data);
        end
      end
      step(acc);
      if (acc) begin
        if (items[idx].legal) begin
          w.addr = exp_ptr; w.data = items[idx].exp;
          sb.push_back(w);
          exp_ptr = exp_ptr + ADDR_W'(4);
        end
        idx++;
      end
      ncyc++;
      if (ncyc == stall) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    if (idx < items.size()) begin
      checks++; errors++;
      $display("FAIL run_items_timeout accepted=%0d required %0d", idx, items.size());
    end
    items.delete();
  endtask

  task automatic drain();
    int n;
    bit a;
    n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      step(a);
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain got pending=%0d out_valid=%b required 0 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks += 7;
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    if (imem_addr !== '0)    begin errors++; $display("FAIL rst_addr got %h required 0", imem_addr); end
    if (imem_wdata !== '0)   begin errors++; $display("FAIL rst_wdata got %h required 0", imem_wdata); end
    if (word_count !== '0)   begin errors++; $display("FAIL rst_word_count got %0d required 0", word_count); end
    if (err_count !== '0)    begin errors++; $display("FAIL rst_err_count got %0d required 0", err_count); end
    if (err !== 1'b0)        begin errors++; $display("FAIL rst_err got %b required 0", err); end
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
  endtask

  task automatic test_add();
    int n;
    do_start(16'h0100);
    items.push_back(mk(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 32'h8B030041, 1'b1));
    run_items(0, 1'b0, n);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL latency got out_valid=%b required 1", out_valid); end
    drain();
    checks++;
    if (word_count !== 4'd1) begin errors++; $display("FAIL t1_word_count got %0d required 1", word_count); end
  endtask

  task automatic test_imm_bounds();
    int n;
    do_start(16'h0200);
    items.push_back(mk(4'd4, 5'd9, 5'd9, 5'd0, 26'd4095, 2'd0, 32'h913FFD29, 1'b1));
    items.push_back(mk(4'd4, 5'd9, 5'd9, 5'd0, 26'd4096, 2'd0, 32'h0, 1'b0));
    items.push_back(mk(4'd5, 5'd1, 5'd2, 5'd0, 26'd1, 2'd0, 32'hD1000441, 1'b1));
    run_items(0, 1'b0, n);
    drain();
    checks += 3;
    if (err !== 1'b1)        begin errors++; $display("FAIL t2_err got %b required 1", err); end
    if (err_count !== 4'd1)  begin errors++; $display("FAIL t2_err_count got %0d required 1", err_count); end
    if (word_count !== 4'd2) begin errors++; $display("FAIL t2_word_count got %0d required 2", word_count); end
  endtask

  task automatic test_formats();
    int n;
    do_start(16'h0300);
    items.push_back(mk(4'd9,  5'd10, 5'd1,  5'd0,  26'h3FFFFF8, 2'd0, 32'hF85F802A, 1'b1));
    items.push_back(mk(4'd8,  5'd5,  5'd0,  5'd0,  26'h3FFFFFF, 2'd0, 32'hB4FFFFE5, 1'b1));
    items.push_back(mk(4'd7,  5'd31, 5'd31, 5'd31, 26'h3FFFFFF, 2'd3, 32'h17FFFFFF, 1'b1));
    items.push_back(mk(4'd6,  5'd7,  5'd31, 5'd31, 26'h0001234, 2'd2, 32'hD2C24687, 1'b1));
    items.push_back(mk(4'd6,  5'd31, 5'd0,  5'd0,  26'h000FFFF, 2'd3, 32'hD2FFFFFF, 1'b1));
    items.push_back(mk(4'd10, 5'd3,  5'd4,  5'd0,  26'd255,     2'd0, 32'hF80FF083, 1'b1));
    items.push_back(mk(4'd9,  5'd0,  5'd0,  5'd0,  26'h3FFFF00, 2'd0, 32'hF8500000, 1'b1));
    items.push_back(mk(4'd8,  5'd0,  5'd0,  5'd0,  26'h3FC0000, 2'd0, 32'hB4800000, 1'b1));
    items.push_back(mk(4'd0,  5'd2,  5'd3,  5'd4,  26'd0,       2'd0, 32'h8A040062, 1'b1));
    items.push_back(mk(4'd1,  5'd0,  5'd31, 5'd1,  26'd0,       2'd0, 32'hAA0103E0, 1'b1));
    items.push_back(mk(4'd3,  5'd4,  5'd5,  5'd6,  26'd0,       2'd0, 32'hCB0600A4, 1'b1));
    items.push_back(mk(4'd11, 5'd1,  5'd1,  5'd1,  26'd0,       2'd0, 32'h0, 1'b0));
    items.push_back(mk(4'd15, 5'd1,  5'd1,  5'd1,  26'd0,       2'd0, 32'h0, 1'b0));
    items.push_back(mk(4'd6,  5'd1,  5'd0,  5'd0,  26'h0010000, 2'd0, 32'h0, 1'b0));
    items.push_back(mk(4'd9,  5'd1,  5'd1,  5'd0,  26'd256,     2'd0, 32'h0, 1'b0));
    items.push_back(mk(4'd10, 5'd1,  5'd1,  5'd0,  26'h3FFFEFF, 2'd0, 32'h0, 1'b0));
    items.push_back(mk(4'd8,  5'd1,  5'd0,  5'd0,  26'h0040000, 2'd0, 32'h0, 1'b0));
    run_items(0, 1'b0, n);
    drain();
    checks += 2;
    if (word_count !== 4'd11) begin errors++; $display("FAIL t3_word_count got %0d required 11", word_count); end
    if (err_count !== 4'd6)   begin errors++; $display("FAIL t3_err_count got %0d required 6", err_count); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(16'h0400);
    pop_cyc.delete();
    items.push_back(mk(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 32'h8B030041, 1'b1));
    items.push_back(mk(4'd3, 5'd4, 5'd5, 5'd6, 26'd0, 2'd0, 32'hCB0600A4, 1'b1));
    items.push_back(mk(4'd0, 5'd2, 5'd3, 5'd4, 26'd0, 2'd0, 32'h8A040062, 1'b1));
    run_items(5, 1'b1, n);
    checks++;
    if (n != 7) begin errors++; $display("FAIL t4_accept_cycles got %0d required 7", n); end
    drain();
    checks += 2;
    if (pop_cyc.size() != 3 || pop_cyc[1] != pop_cyc[0] + 1 || pop_cyc[2] != pop_cyc[1] + 1) begin
      errors++;
      $display("FAIL t4_stream got %0d writes not one per cycle required 3 consecutive", pop_cyc.size());
    end
    if (word_count !== 4'd3) begin errors++; $display("FAIL t4_word_count got %0d required 3", word_count); end
  endtask

  task automatic test_wrap();
    int n;
    do_start(16'hFFFF);
    items.push_back(mk(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 32'h8B030041, 1'b1));
    items.push_back(mk(4'd1, 5'd0, 5'd31, 5'd1, 26'd0, 2'd0, 32'hAA0103E0, 1'b1));
    run_items(0, 1'b0, n);
    drain();
    checks++;
    if (word_count !== 4'd2) begin errors++; $display("FAIL t5_word_count got %0d required 2", word_count); end
  endtask

  task automatic test_start_flush();
    int n;
    bit a;
    do_start(16'h0500);
    items.push_back(mk(4'd12, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 32'h0, 1'b0));
    items.push_back(mk(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 32'h8B030041, 1'b1));
    run_items(100, 1'b0, n);
    start = 1'b1; base_addr = 16'h0500; in_valid = 1'b1; out_ready = 1'b0;
    op = 4'd3; rd = 5'd4; rn = 5'd5; rm = 5'd6; imm = 26'd0; hw = 2'd0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL t6_in_ready got %b required 0", in_ready); end
    step(a);
    start = 1'b0; in_valid = 1'b0;
    sb.delete();
    exp_ptr = 16'h0500;
    checks += 5;
    if (out_valid !== 1'b0)    begin errors++; $display("FAIL t6_out_valid got %b required 0", out_valid); end
    if (word_count !== 4'd0)   begin errors++; $display("FAIL t6_word_count got %0d required 0", word_count); end
    if (err !== 1'b0)          begin errors++; $display("FAIL t6_err got %b required 0", err); end
    if (err_count !== 4'd0)    begin errors++; $display("FAIL t6_err_count got %0d required 0", err_count); end
    if (imem_addr !== 16'h0500) begin errors++; $display("FAIL t6_addr got %h required 0500", imem_addr); end
    items.push_back(mk(4'd3, 5'd4, 5'd5, 5'd6, 26'd0, 2'd0, 32'hCB0600A4, 1'b1));
    run_items(0, 1'b0, n);
    drain();
    checks++;
    if (word_count !== 4'd1) begin errors++; $display("FAIL t6_after_word_count got %0d required 1", word_count); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit a;
    do_start(16'h0600);
    items.push_back(mk(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 32'h8B030041, 1'b1));
    run_items(100, 1'b0, n);
    reset = 1'b1;
    step(a);
    reset = 1'b0;
    sb.delete();
    exp_ptr = '0;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b required 0", out_valid); end
    if (imem_addr !== '0)   begin errors++; $display("FAIL mid_rst_addr got %h required 0", imem_addr); end
    if (imem_wdata !== '0)  begin errors++; $display("FAIL mid_rst_wdata got %h required 0", imem_wdata); end
    items.push_back(mk(4'd1, 5'd0, 5'd31, 5'd1, 26'd0, 2'd0, 32'hAA0103E0, 1'b1));
    run_items(0, 1'b0, n);
    drain();
  endtask

  task automatic test_saturate();
    int n;
    do_start(16'h0700);
    for (int i = 0; i < 17; i++) items.push_back(mk(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 32'h8B030041, 1'b1));
    for (int i = 0; i < 17; i++) items.push_back(mk(4'd13, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 32'h0, 1'b0));
    run_items(0, 1'b0, n);
    drain();
    checks += 2;
    if (word_count !== 4'hF) begin errors++; $display("FAIL sat_word_count got %0d required 15", word_count); end
    if (err_count !== 4'hF)  begin errors++; $display("FAIL sat_err_count got %0d required 15", err_count); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; rd = '0; rn = '0; rm = '0; imm = '0; hw = '0;
    exp_ptr = '0;
    @(posedge CLK);
    #2;
    repeat (2) begin
      @(posedge CLK);
      #2;
    end
    reset = 1'b0;
    test_reset();
    test_add();
    test_imm_bounds();
    test_formats();
    test_back_to_back();
    test_wrap();
    test_start_flush();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
